// File: rtl/alu_result_collector_if.sv
// Issue/result interface of alu_result_collector: issue side toward alu_top, result side downstream.
// The slave modport is the collector's view of the bus; master is the driver/consumer side.
interface alu_result_collector_if;
  logic        issue_valid;
  logic [3:0]  issue_op;
  logic [31:0] alu_out;
  logic        zero_flag;
  logic        res_valid;
  logic        res_ready;
  logic [3:0]  res_op;
  logic [31:0] res_data;
  logic        res_zero;

  modport master (
    output issue_valid, issue_op, alu_out, zero_flag, res_ready,
    input  res_valid, res_op, res_data, res_zero
  );

  modport slave (
    input  issue_valid, issue_op, alu_out, zero_flag, res_ready,
    output res_valid, res_op, res_data, res_zero
  );
endinterface

// File: rtl/alu_result_collector.sv
// Tags ALU ops, aligns tags with alu_top's output, buffers results in a FWFT FIFO and keeps statistics.
// Optional zero-flag consistency check enabled by defining ALU_RESULT_CHECK_EN.
module alu_result_collector #(
  parameter int DEPTH       = 8,
  parameter int ALU_LATENCY = 1,
  parameter int CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 clear,
  alu_result_collector_if.slave bus,
  output logic                 fifo_full,
  output logic                 overflow,
  output logic [CNT_W-1:0]     result_count,
  output logic [CNT_W-1:0]     zero_count,
  output logic                 flag_err,
  output logic [3:0]           err_op
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 37;
  localparam logic [AW:0]      PTR_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  // Delay line entries are {valid, op}; the last stage lines up with alu_out.
  logic [4:0] dl_reg [ALU_LATENCY];
  logic       cap_valid;
  logic [3:0] cap_op;

  always_ff @(posedge clk) begin
    if (clear) begin
      for (int i = 0; i < ALU_LATENCY; i++) dl_reg[i] <= '0;
    end else begin
      dl_reg[0] <= {bus.issue_valid, bus.issue_op};
      for (int i = 1; i < ALU_LATENCY; i++) dl_reg[i] <= dl_reg[i-1];
    end
  end

  assign cap_valid = dl_reg[ALU_LATENCY-1][4];
  assign cap_op    = dl_reg[ALU_LATENCY-1][3:0];

  logic [AW:0]   wr_ptr_reg;
  logic [AW:0]   rd_ptr_reg;
  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] head;
  logic          empty;
  logic          full;
  logic          pop;
  logic          push_ok;

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign pop     = !empty && bus.res_ready;
  // A pop in the same cycle frees the slot the push lands in, so full only blocks without one.
  assign push_ok = cap_valid && (!full || pop);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg[AW-1:0]] <= {cap_op, bus.alu_out, bus.zero_flag};
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop)     rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
    end
  end

  assign head = mem[rd_ptr_reg[AW-1:0]];

  always_comb begin
    bus.res_valid = !empty;
    bus.res_op    = 4'd0;
    bus.res_data  = 32'd0;
    bus.res_zero  = 1'b0;
    if (!empty) begin
      bus.res_op   = head[36:33];
      bus.res_data = head[32:1];
      bus.res_zero = head[0];
    end
  end

  assign fifo_full = full;

  logic             overflow_reg;
  logic [CNT_W-1:0] result_count_reg;
  logic [CNT_W-1:0] zero_count_reg;

  always_ff @(posedge clk) begin
    if (clear) begin
      overflow_reg     <= 1'b0;
      result_count_reg <= '0;
      zero_count_reg   <= '0;
    end else begin
      if (cap_valid && !push_ok) overflow_reg <= 1'b1;
      if (push_ok) begin
        if (!(&result_count_reg)) result_count_reg <= result_count_reg + CNT_ONE;
        if (bus.zero_flag && !(&zero_count_reg)) zero_count_reg <= zero_count_reg + CNT_ONE;
      end
    end
  end

  assign overflow     = overflow_reg;
  assign result_count = result_count_reg;
  assign zero_count   = zero_count_reg;

`ifdef ALU_RESULT_CHECK_EN
  logic       flag_err_reg;
  logic [3:0] err_op_reg;
  logic       flag_mismatch;

  assign flag_mismatch = bus.zero_flag != (bus.alu_out == 32'd0);

  // err_op is frozen at the first offending op; later errors only keep flag_err set.
  always_ff @(posedge clk) begin
    if (clear) begin
      flag_err_reg <= 1'b0;
      err_op_reg   <= 4'd0;
    end else if (push_ok && flag_mismatch && !flag_err_reg) begin
      flag_err_reg <= 1'b1;
      err_op_reg   <= cap_op;
    end
  end

  assign flag_err = flag_err_reg;
  assign err_op   = err_op_reg;
`else
  assign flag_err = 1'b0;
  assign err_op   = 4'd0;
`endif

endmodule

// File: tb/tb_alu_result_collector.sv
// Self-checking bench for alu_result_collector: a latency-1 ALU model feeds the DUT and a
// queue-based reference predicts FIFO contents, statistics and the optional flag check.
module tb_alu_result_collector;
  localparam int DEPTH = 8;
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic clk = 1'b0;
  logic clear;
  logic fifo_full, overflow, flag_err;
  logic [CNT_W-1:0] result_count, zero_count;
  logic [3:0] err_op;
  logic [31:0] alu_a, alu_b;
  logic bad_inj;

  int checks = 0;
  int errors = 0;

  alu_result_collector_if bus();

  alu_result_collector #(.DEPTH(DEPTH), .ALU_LATENCY(1), .CNT_W(CNT_W)) dut (
    .clk(clk), .clear(clear), .bus(bus),
    .fifo_full(fifo_full), .overflow(overflow),
    .result_count(result_count), .zero_count(zero_count),
    .flag_err(flag_err), .err_op(err_op)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6: return (a < b) ? 32'd1 : 32'd0;
      4'd7: return a << b[4:0];
      4'd8: return a >> b[4:0];
      default: return 32'd0;
    endcase
  endfunction

  // Stand-in for alu_top: registered result one cycle after the operands are applied.
  always @(posedge clk) begin
    bus.alu_out   <= alu_ref(bus.issue_op, alu_a, alu_b);
    bus.zero_flag <= (alu_ref(bus.issue_op, alu_a, alu_b) == 32'd0) ^ bad_inj;
  end

  typedef struct {
    logic [3:0]  op;
    logic [31:0] d;
    logic        z;
  } ent_t;

  ent_t q[$];
  logic inf_v;
  ent_t inf_e;
  logic [CNT_W-1:0] m_rc, m_zc;
  logic m_ovf, m_ferr;
  logic [3:0] m_eop;

  task automatic step(input logic clr, input logic iv, input logic [3:0] op,
                      input logic [31:0] a, input logic [31:0] b, input logic rdy, input logic bad);
    logic pop, do_push;
    clear = clr; bus.issue_valid = iv; bus.issue_op = op;
    alu_a = a; alu_b = b; bad_inj = bad; bus.res_ready = rdy;
    if (clr) begin
      q.delete(); inf_v = 1'b0;
      m_rc = '0; m_zc = '0; m_ovf = 1'b0; m_ferr = 1'b0; m_eop = 4'd0;
    end else begin
      pop = (q.size() > 0) && rdy;
      do_push = 1'b0;
      if (inf_v) begin
        if (q.size() == DEPTH && !pop) m_ovf = 1'b1;
        else do_push = 1'b1;
      end
      if (pop) void'(q.pop_front());
      if (do_push) begin
        q.push_back(inf_e);
        if (m_rc != CNT_MAX) m_rc = m_rc + 1'b1;
        if (inf_e.z && m_zc != CNT_MAX) m_zc = m_zc + 1'b1;
`ifdef ALU_RESULT_CHECK_EN
        if (inf_e.z != (inf_e.d == 32'd0) && !m_ferr) begin
          m_ferr = 1'b1; m_eop = inf_e.op;
        end
`endif
      end
      inf_v = iv;
      inf_e.op = op;
      inf_e.d  = alu_ref(op, a, b);
      inf_e.z  = (alu_ref(op, a, b) == 32'd0) ^ bad;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, rdy, 1'b0);
  endtask

  task automatic test_reset;
    step(1'b1, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got %0b exp 0", bus.res_valid); end
    checks++; if ({bus.res_op, bus.res_data, bus.res_zero} !== 37'd0) begin errors++; $display("FAIL reset_res_fields got %0h exp 0", {bus.res_op, bus.res_data, bus.res_zero}); end
    checks++; if ({fifo_full, overflow, flag_err, err_op} !== 7'd0) begin errors++; $display("FAIL reset_flags got %0h exp 0", {fifo_full, overflow, flag_err, err_op}); end
    checks++; if ({result_count, zero_count} !== '0) begin errors++; $display("FAIL reset_counts got %0h/%0h exp 0/0", result_count, zero_count); end
    $display("reset: res_valid=%0b counts=%0d/%0d", bus.res_valid, result_count, zero_count);
  endtask

  task automatic test_single_latency;
    step(1'b1, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'd0, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
    checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL lat_early_valid got %0b exp 0", bus.res_valid); end
    idle(1'b0);
    checks++; if (bus.res_valid !== 1'b1) begin errors++; $display("FAIL lat_valid got %0b exp 1", bus.res_valid); end
    checks++; if ({bus.res_op, bus.res_data, bus.res_zero} !== {4'd0, 32'd0, 1'b1}) begin errors++; $display("FAIL lat_head got op=%0d data=%0h z=%0b exp op=0 data=0 z=1", bus.res_op, bus.res_data, bus.res_zero); end
    checks++; if (zero_count !== 4'd1) begin errors++; $display("FAIL lat_zero_count got %0d exp 1", zero_count); end
    $display("single ADD: op=%0d data=%0h zero=%0b", bus.res_op, bus.res_data, bus.res_zero);
    idle(1'b1);
    checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL lat_pop_empty got %0b exp 0", bus.res_valid); end
  endtask

  task automatic test_back_to_back;
    logic [32:0] got[$];
    logic [32:0] exp_v [3];
    exp_v[0] = {32'd0, 1'b1}; exp_v[1] = {32'd1, 1'b0}; exp_v[2] = {32'd1, 1'b0};
    step(1'b1, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      if (bus.res_valid) got.push_back({bus.res_data, bus.res_zero});
      case (i)
        0: step(1'b0, 1'b1, 4'd1, 32'd10, 32'd10, 1'b1, 1'b0);
        1: step(1'b0, 1'b1, 4'd6, 32'd20, 32'd40, 1'b1, 1'b0);
        2: step(1'b0, 1'b1, 4'd5, -32'sd20, 32'd40, 1'b1, 1'b0);
        default: idle(1'b1);
      endcase
    end
    checks++; if (got.size() != 3) begin errors++; $display("FAIL b2b_count got %0d exp 3", got.size()); end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      checks++; if (got[i] !== exp_v[i]) begin errors++; $display("FAIL b2b_result%0d got %0h exp %0h", i, got[i], exp_v[i]); end
      $display("b2b result %0d: data=%0h zero=%0b", i, got[i][32:1], got[i][0]);
    end
    checks++; if (result_count !== 4'd3) begin errors++; $display("FAIL b2b_result_count got %0d exp 3", result_count); end
  endtask

  task automatic test_overflow;
    step(1'b1, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      step(1'b0, 1'b1, 4'($urandom_range(0, 8)), $urandom, $urandom, 1'b0, 1'b0);
      if (i == 7) begin
        checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL ovf_full_early got %0b exp 0", fifo_full); end
      end
      if (i == 8) begin
        checks++; if (fifo_full !== 1'b1 || overflow !== 1'b0) begin errors++; $display("FAIL ovf_full_at_8 got full=%0b ovf=%0b exp 1/0", fifo_full, overflow); end
      end
    end
    idle(1'b0);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %0b exp 1", overflow); end
    checks++; if (result_count !== 4'd8) begin errors++; $display("FAIL ovf_result_count got %0d exp 8", result_count); end
    checks++; if ({bus.res_op, bus.res_data, bus.res_zero} !== {q[0].op, q[0].d, q[0].z}) begin errors++; $display("FAIL ovf_head got %0h exp %0h", {bus.res_op, bus.res_data, bus.res_zero}, {q[0].op, q[0].d, q[0].z}); end
    $display("overflow: full=%0b overflow=%0b result_count=%0d", fifo_full, overflow, result_count);
  endtask

  task automatic test_full_pop;
    ent_t second, newest;
    step(1'b1, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 4'($urandom_range(0, 8)), $urandom, $urandom, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'd4, $urandom, $urandom, 1'b0, 1'b0);
    checks++; if (fifo_full !== 1'b1 || overflow !== 1'b0) begin errors++; $display("FAIL fp_prefull got full=%0b ovf=%0b exp 1/0", fifo_full, overflow); end
    second = q[1];
    newest = inf_e;
    idle(1'b1);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fp_overflow got %0b exp 0", overflow); end
    checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL fp_full got %0b exp 1", fifo_full); end
    checks++; if ({bus.res_op, bus.res_data, bus.res_zero} !== {second.op, second.d, second.z}) begin errors++; $display("FAIL fp_head got %0h exp %0h", {bus.res_op, bus.res_data, bus.res_zero}, {second.op, second.d, second.z}); end
    checks++; if (result_count !== 4'd9) begin errors++; $display("FAIL fp_result_count got %0d exp 9", result_count); end
    for (int i = 0; i < 8; i++) begin
      if (i == 7) begin
        checks++; if ({bus.res_op, bus.res_data, bus.res_zero} !== {newest.op, newest.d, newest.z}) begin errors++; $display("FAIL fp_tail got %0h exp %0h", {bus.res_op, bus.res_data, bus.res_zero}, {newest.op, newest.d, newest.z}); end
      end else begin
        checks++; if ({bus.res_op, bus.res_data, bus.res_zero} !== {q[0].op, q[0].d, q[0].z}) begin errors++; $display("FAIL fp_drain%0d got %0h exp %0h", i, {bus.res_op, bus.res_data, bus.res_zero}, {q[0].op, q[0].d, q[0].z}); end
      end
      idle(1'b1);
    end
    checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL fp_drained got %0b exp 0", bus.res_valid); end
    $display("full+pop: head and tail order checked, overflow=%0b", overflow);
  endtask

  task automatic test_clear_inflight;
    step(1'b1, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 4'($urandom_range(0, 8)), $urandom, $urandom, 1'b0, 1'b0);
    step(1'b1, 1'b1, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL clr_res_valid got %0b exp 0", bus.res_valid); end
    checks++; if ({result_count, zero_count} !== '0 || overflow !== 1'b0 || fifo_full !== 1'b0) begin errors++; $display("FAIL clr_state got rc=%0d zc=%0d ovf=%0b full=%0b exp 0", result_count, zero_count, overflow, fifo_full); end
    for (int i = 0; i < 4; i++) begin
      idle(1'b1);
      checks++; if (bus.res_valid !== 1'b0 || result_count !== '0) begin errors++; $display("FAIL clr_stale%0d got valid=%0b rc=%0d exp 0/0", i, bus.res_valid, result_count); end
    end
    $display("clear in flight: res_valid=%0b result_count=%0d", bus.res_valid, result_count);
  endtask

  task automatic test_saturation;
    step(1'b1, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 4'd1, 32'd7, 32'd7, 1'b1, 1'b0);
    idle(1'b1);
    checks++; if (result_count !== CNT_MAX) begin errors++; $display("FAIL sat_result_count got %0d exp %0d", result_count, CNT_MAX); end
    checks++; if (zero_count !== CNT_MAX) begin errors++; $display("FAIL sat_zero_count got %0d exp %0d", zero_count, CNT_MAX); end
    $display("saturation: result_count=%0d zero_count=%0d", result_count, zero_count);
  endtask

  task automatic test_flag_check;
    step(1'b1, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'd4, 32'h5A5A, 32'h5A5A, 1'b1, 1'b1);
    idle(1'b1);
`ifdef ALU_RESULT_CHECK_EN
    checks++; if (flag_err !== 1'b1 || err_op !== 4'd4) begin errors++; $display("FAIL flag_first got err=%0b op=%0d exp 1/4", flag_err, err_op); end
`else
    checks++; if (flag_err !== 1'b0 || err_op !== 4'd0) begin errors++; $display("FAIL flag_disabled got err=%0b op=%0d exp 0/0", flag_err, err_op); end
`endif
    step(1'b0, 1'b1, 4'd0, 32'd3, 32'd4, 1'b1, 1'b1);
    idle(1'b1);
    checks++; if (flag_err !== m_ferr || err_op !== m_eop) begin errors++; $display("FAIL flag_second got err=%0b op=%0d exp %0b/%0d", flag_err, err_op, m_ferr, m_eop); end
    $display("flag check: flag_err=%0b err_op=%0d", flag_err, err_op);
  endtask

  task automatic test_random;
    step(1'b1, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a, b;
      a = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, 4'($urandom_range(0, 9)),
           a, b, $urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0);
      checks++; if (bus.res_valid !== (q.size() != 0)) begin errors++; $display("FAIL rnd_valid cyc %0d got %0b exp %0b", i, bus.res_valid, q.size() != 0); end
      if (q.size() != 0) begin
        checks++; if ({bus.res_op, bus.res_data, bus.res_zero} !== {q[0].op, q[0].d, q[0].z}) begin errors++; $display("FAIL rnd_head cyc %0d got %0h exp %0h", i, {bus.res_op, bus.res_data, bus.res_zero}, {q[0].op, q[0].d, q[0].z}); end
      end
      checks++; if (fifo_full !== (q.size() == DEPTH) || overflow !== m_ovf) begin errors++; $display("FAIL rnd_flags cyc %0d got full=%0b ovf=%0b exp %0b/%0b", i, fifo_full, overflow, q.size() == DEPTH, m_ovf); end
      checks++; if (result_count !== m_rc || zero_count !== m_zc) begin errors++; $display("FAIL rnd_counts cyc %0d got %0d/%0d exp %0d/%0d", i, result_count, zero_count, m_rc, m_zc); end
      checks++; if (flag_err !== m_ferr || err_op !== m_eop) begin errors++; $display("FAIL rnd_flagerr cyc %0d got %0b/%0d exp %0b/%0d", i, flag_err, err_op, m_ferr, m_eop); end
    end
    $display("random: 400 cycles, occupancy=%0d result_count=%0d", q.size(), result_count);
  endtask

  initial begin
    clear = 1'b1; bus.issue_valid = 1'b0; bus.issue_op = 4'd0; bus.res_ready = 1'b0;
    alu_a = 32'd0; alu_b = 32'd0; bad_inj = 1'b0;
    inf_v = 1'b0; inf_e.op = 4'd0; inf_e.d = 32'd0; inf_e.z = 1'b0;
    m_rc = '0; m_zc = '0; m_ovf = 1'b0; m_ferr = 1'b0; m_eop = 4'd0;
    @(posedge clk); #1;
    test_reset();
    test_single_latency();
    test_back_to_back();
    test_overflow();
    test_full_pop();
    test_clear_inflight();
    test_saturation();
    test_flag_check();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
